core_seq: RTL and testbench
===========================

CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 5, meaning the width of the vector-length and read-address fields (matrix depth 32).
REQ-002 SHALL have parameter NC_W, default 4, meaning the width of the output-chain core-count field.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a dot-product pass, sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_W, the number of products minus one, latched on accepted start.
REQ-007 SHALL have port ncore, input, NC_W, the number of chain shifts minus one, latched on accepted start.
REQ-008 SHALL have ports in_valid, input, 1, and in_data, input, 32, an FP32 activation stream.
REQ-009 SHALL have port in_ready, output, 1, asserted only in RUN.
REQ-010 SHALL have ports init, exec and outr (each output, 1), and update (output, 1), as MAC-array controls.
REQ-011 SHALL have port ra, output, LEN_W, the weight read address.
REQ-012 SHALL have port d, output, 32, the registered activation.
REQ-013 SHALL have port out_valid, output, 1, marking each chain-shift cycle.
REQ-014 SHALL have port out_ready, input, 1, for downstream backpressure.
REQ-015 SHALL have ports busy and done, outputs, 1 each.

Function
REQ-016 SHALL implement FSM IDLE->INIT->RUN->DRAIN->SHIFT->IDLE.
REQ-017 IDLE: start=1 SHALL latch len/ncore and go to INIT; busy=0 only in IDLE.
REQ-018 INIT: exactly one cycle; SHALL assert init=1, exec=0, then enter RUN.
REQ-019 RUN: in_valid&in_ready SHALL assert exec=1 the same cycle with ra=element count (starting at 0), and SHALL register in_data onto d for the next cycle.
REQ-020 The count SHALL increment per accepted element; gaps (in_valid=0) SHALL hold exec=0 and count.
REQ-021 Acceptance of element len SHALL move to DRAIN; count SHALL never wrap in a pass.
REQ-022 DRAIN: exactly 2 cycles with all array controls low, covering the array's 2-cycle multiply-accumulate lag.
REQ-023 SHIFT: first cycle SHALL assert update=1 and outr=1; later cycles outr=1, update=0.
REQ-024 SHIFT SHALL issue ncore+1 outr cycles; out_valid SHALL equal outr.
REQ-025 After the final shift, done SHALL pulse one cycle and the FSM SHALL return to IDLE.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 init, exec and outr SHALL be mutually exclusive in every cycle.
REQ-028 ra and d SHALL be registered outputs; d holds its last value when not updated.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, count=0, and every output to 0 (d=32'h0, ra=0), including mid-pass.
REQ-030 After reset release, the first start SHALL run a complete pass with a fresh init.

Configuration
REQ-031 With CORE_SEQ_BACKPRESSURE_EN defined, out_ready=0 in SHIFT SHALL hold outr/out_valid low and freeze the shift count and the update-pending flag; shifting resumes when out_ready=1.
REQ-032 Without CORE_SEQ_BACKPRESSURE_EN, out_ready SHALL be ignored and SHIFT SHALL run ncore+1 back-to-back cycles.

Verification
REQ-033 Reset, start, len=3, ncore=0, in_valid held 1 with data 1.0..4.0 -> init at cycle 1; exec cycles 2-5 with ra=0..3; d=1.0..4.0 in cycles 3-6; DRAIN cycles 6-7; update=outr=1 at cycle 8; done at cycle 9.
REQ-034 len=2 with in_valid low for 3 cycles between elements 0 and 1 -> exec count=3, ra=0,1,2, no exec during gaps, DRAIN starts after third accept.
REQ-035 ncore=3 -> outr high exactly 4 consecutive cycles, update only on the first, out_valid matches outr.
REQ-036 BACKPRESSURE_EN, ncore=2, out_ready low for 2 cycles after the first shift -> 3 total outr cycles, none while out_ready=0, single update pulse.
REQ-037 rst_n low during RUN at ra=5 -> all outputs 0 immediately; next start restarts at INIT with ra=0.
REQ-038 start pulsed during RUN and SHIFT -> no effect on count, latched len or done timing.

Source files
------------

// File: rtl/core_seq_if.sv
// core_seq_if: activation-stream and output-chain handshake bundle.
//   in_valid/in_data/in_ready : FP32 activation stream into the sequencer
//   out_valid/out_ready       : chain-shift strobe and downstream backpressure
// Modports: master = producer/consumer side (bench or upstream logic),
//           slave  = core_seq side.
interface core_seq_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid
  );
endinterface

// File: rtl/core_seq.sv
// core_seq: dot-product pass sequencer for a MAC array.
//   IDLE -> INIT (1 cycle) -> RUN (len+1 accepted elements) -> DRAIN (2 cycles)
//   -> SHIFT (ncore+1 chain shifts) -> IDLE with a one-cycle done pulse.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : pass request, sampled only in IDLE
//   len, ncore      : products-1 and chain-shifts-1, latched on accepted start
//   sif (slave)     : in_valid/in_data/in_ready stream, out_valid/out_ready
//   init/exec/outr/update : MAC-array controls (init, exec, outr one-hot or idle)
//   ra              : weight read address (registered element count)
//   d               : registered activation, holds when not updated
//   busy, done      : pass in progress / pass-complete pulse
// Build option: define CORE_SEQ_BACKPRESSURE_EN to let out_ready=0 stall SHIFT.
module core_seq #(
  parameter int unsigned LEN_W = 5,
  parameter int unsigned NC_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [NC_W-1:0]  ncore,
  core_seq_if.slave        sif,
  output logic             init,
  output logic             exec,
  output logic             outr,
  output logic             update,
  output logic [LEN_W-1:0] ra,
  output logic [31:0]      d,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, SHIFT} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [NC_W-1:0]  nc_q;
  logic [NC_W-1:0]  sh_cnt;
  logic             drain_cnt;
  logic             upd_pend;
  logic             init_q;
  logic             run_q;
  logic             shift_q;
  logic             accept;
  logic             shift_go;

  // exec/outr follow the same-cycle handshake, gated by registered phase flags.
  assign accept = run_q & sif.in_valid;

`ifdef CORE_SEQ_BACKPRESSURE_EN
  assign shift_go = shift_q & sif.out_ready;
`else
  logic unused_out_ready;
  assign unused_out_ready = sif.out_ready;
  assign shift_go = shift_q;
`endif

  assign init          = init_q;
  assign exec          = accept;
  assign outr          = shift_go;
  assign update        = shift_go & upd_pend;
  assign sif.in_ready  = run_q;
  assign sif.out_valid = shift_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      nc_q      <= '0;
      ra        <= '0;
      sh_cnt    <= '0;
      drain_cnt <= 1'b0;
      upd_pend  <= 1'b0;
      init_q    <= 1'b0;
      run_q     <= 1'b0;
      shift_q   <= 1'b0;
      d         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q  <= len;
            nc_q   <= ncore;
            ra     <= '0;
            init_q <= 1'b1;
            busy   <= 1'b1;
            state  <= INIT;
          end
        end
        INIT: begin
          init_q <= 1'b0;
          run_q  <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          if (accept) begin
            d <= sif.in_data;
            // Last element leaves ra at len so the count never wraps.
            if (ra == len_q) begin
              run_q     <= 1'b0;
              drain_cnt <= 1'b0;
              state     <= DRAIN;
            end else begin
              ra <= ra + LEN_W'(1);
            end
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            shift_q  <= 1'b1;
            sh_cnt   <= '0;
            upd_pend <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_go) begin
            upd_pend <= 1'b0;
            if (sh_cnt == nc_q) begin
              shift_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              sh_cnt <= sh_cnt + NC_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq.sv
module tb_core_seq;
  localparam int LW = 5;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [NW-1:0] ncore = '0;
  logic          init, exec, outr, update, busy, done;
  logic [LW-1:0] ra;
  logic [31:0]   d;

  core_seq_if sif ();

  core_seq #(.LEN_W(LW), .NC_W(NW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .len    (len),
    .ncore  (ncore),
    .sif    (sif),
    .init   (init),
    .exec   (exec),
    .outr   (outr),
    .update (update),
    .ra     (ra),
    .d      (d),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a pass is described by its age since start, the number
  // of accepted elements, cycles since the final accept and shifts issued.
  bit          m_act;
  bit          m_done;
  int          m_age, m_acc, m_tail, m_sh, m_len, m_nc, m_ra;
  logic [31:0] m_d;
  bit          e_run, e_init, e_exec, e_win, e_outr, e_upd, nd;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_init", init, 0);  chk("rst_exec", exec, 0);
      chk("rst_outr", outr, 0);  chk("rst_update", update, 0);
      chk("rst_ra", ra, 0);      chk("rst_d", d, 0);
      chk("rst_busy", busy, 0);  chk("rst_done", done, 0);
      chk("rst_in_ready", sif.in_ready, 0);
      chk("rst_out_valid", sif.out_valid, 0);
      m_act = 0; m_done = 0; m_age = 0; m_acc = 0; m_tail = -1;
      m_sh = 0; m_ra = 0; m_d = '0;
    end else begin
      e_run  = m_act && m_age >= 2 && m_tail < 0;
      e_init = m_act && m_age == 1;
      e_exec = e_run && sif.in_valid;
      e_win  = m_act && m_tail >= 3;
`ifdef CORE_SEQ_BACKPRESSURE_EN
      e_outr = e_win && sif.out_ready;
`else
      e_outr = e_win;
`endif
      e_upd = e_outr && m_sh == 0;

      chk("init", init, 32'(e_init));
      chk("exec", exec, 32'(e_exec));
      chk("in_ready", sif.in_ready, 32'(e_run));
      chk("outr", outr, 32'(e_outr));
      chk("out_valid", sif.out_valid, 32'(e_outr));
      chk("update", update, 32'(e_upd));
      chk("ra", 32'(ra), 32'(m_ra));
      chk("d", d, m_d);
      chk("busy", busy, 32'(m_act));
      chk("done", done, 32'(m_done));

      nd = 0;
      if (!m_act) begin
        if (start) begin
          m_act = 1; m_age = 1; m_acc = 0; m_tail = -1; m_sh = 0; m_ra = 0;
          m_len = int'(len); m_nc = int'(ncore);
        end
      end else begin
        m_age++;
        if (m_tail >= 1) m_tail++;
        if (e_exec) begin
          m_d = sif.in_data;
          if (m_acc == m_len) m_tail = 1;
          else m_ra++;
          m_acc++;
        end
        if (e_outr) begin
          m_sh++;
          if (m_sh == m_nc + 1) begin
            m_act = 0;
            nd = 1;
          end
        end
      end
      m_done = nd;
    end
  end

  logic [31:0] fpv [4];

  initial begin
    fpv[0] = 32'h3F80_0000; fpv[1] = 32'h4000_0000;
    fpv[2] = 32'h4040_0000; fpv[3] = 32'h4080_0000;
    sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Hand-timed pass: len=3, ncore=0, data 1.0..4.0, start in cycle 0.
    for (int c = 0; c <= 10; c++) begin
      start = (c == 0);
      len = 5'd3;
      ncore = 4'd0;
      sif.in_valid = 1'b1;
      sif.in_data = (c >= 2 && c <= 5) ? fpv[c-2] : 32'h0;
      sif.out_ready = 1'b1;
      @(negedge clk);
      chk("lit_init", init, 32'(c == 1));
      chk("lit_exec", exec, 32'(c >= 2 && c <= 5));
      chk("lit_update", update, 32'(c == 8));
      chk("lit_outr", outr, 32'(c == 8));
      chk("lit_done", done, 32'(c == 9));
      if (c >= 2 && c <= 5) chk("lit_ra", 32'(ra), 32'(c - 2));
      if (c >= 3 && c <= 6) chk("lit_d", d, fpv[c-3]);
      @(posedge clk);
      #1;
    end

    // Randomized traffic: gaps, backpressure, stray starts, rare resets.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 6) == 0;
      len = ($urandom % 4 == 0) ? LW'($urandom_range(0, 31)) : LW'($urandom_range(0, 5));
      ncore = NW'($urandom_range(0, 15));
      sif.in_valid = ($urandom % 4) != 0;
      sif.in_data = $urandom;
      sif.out_ready = ($urandom % 3) != 0;
      rst_n = ($urandom % 500) != 0;
      @(posedge clk);
      #1;
    end

    rst_n = 1'b1;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
